// File: rtl/obuf_writeback.sv
// obuf_writeback: drains a finished tile from output_buffer into output_memory with strided write addresses.
// Optional cycle counter output wb_cycles is built when OBUF_WB_PERF_EN is defined.
module obuf_writeback #(
    parameter int OBAW       = 12,
    parameter int OBUF_DEPTH = 4096
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [31:0]     base_addr,
    input  logic [15:0]     num_rows,
    input  logic [15:0]     words_per_row,
    input  logic [31:0]     row_stride,
    input  logic            hold,
    output logic [OBAW-1:0] obuf_rd_addr,
    output logic            obuf_rd_en,
    output logic [31:0]     omem_addr,
    output logic            omem_wr_en,
    output logic            busy,
    output logic            done,
    output logic            err
`ifdef OBUF_WB_PERF_EN
    ,
    output logic [31:0]     wb_cycles
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [15:0]     rows_q, wpr_q, row_q, col_q;
    logic [31:0]     stride_q, row_base_q, addr_q;
    logic [OBAW-1:0] k_q;
    logic            valid_q, err_q;
    logic            accept, degenerate, oversize, last;
    logic [31:0]     total;

    assign total        = 32'(num_rows) * 32'(words_per_row);
    assign accept       = state_q == IDLE && start;
    assign degenerate   = num_rows == 16'd0 || words_per_row == 16'd0;
    assign oversize     = total > 32'(OBUF_DEPTH);
    assign last         = col_q == wpr_q - 16'd1 && row_q == rows_q - 16'd1;
    assign obuf_rd_en   = state_q == RUN && !hold;
    assign obuf_rd_addr = obuf_rd_en ? k_q : '0;
    assign omem_wr_en   = valid_q;
    assign omem_addr    = valid_q ? addr_q : '0;
    assign busy         = state_q == RUN || state_q == DRAIN;
    assign done         = state_q == DONE;
    assign err          = err_q;

    // State register; reset aborts any tile in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state; empty or oversized tiles skip RUN and pass through DRAIN so done still comes 2 cycles after start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (degenerate || oversize) ? DRAIN : RUN;
            RUN:     if (obuf_rd_en && last) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the tile on start, then walk rows/columns and register each write target beside its read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_q     <= '0;
            wpr_q      <= '0;
            stride_q   <= '0;
            row_base_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
            k_q        <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            valid_q <= obuf_rd_en;
            if (accept) begin
                rows_q     <= num_rows;
                wpr_q      <= words_per_row;
                stride_q   <= row_stride;
                row_base_q <= base_addr;
                row_q      <= '0;
                col_q      <= '0;
                k_q        <= '0;
                err_q      <= oversize;
            end else if (obuf_rd_en) begin
                addr_q <= row_base_q + 32'(col_q);
                k_q    <= k_q + OBAW'(1);
                if (col_q == wpr_q - 16'd1) begin
                    col_q      <= '0;
                    row_q      <= row_q + 16'd1;
                    row_base_q <= row_base_q + stride_q;
                end else begin
                    col_q <= col_q + 16'd1;
                end
            end
        end
    end

`ifdef OBUF_WB_PERF_EN
    logic [31:0] wb_cycles_q;

    // Count busy cycles of the current tile, stalls included; value holds after done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      wb_cycles_q <= '0;
        else if (accept) wb_cycles_q <= '0;
        else if (busy)   wb_cycles_q <= wb_cycles_q + 32'd1;
    end

    assign wb_cycles = wb_cycles_q;
`endif
endmodule

// File: tb/tb_obuf_writeback.sv
// tb_obuf_writeback: scoreboard bench for obuf_writeback with a loop-based tile address model.
module tb_obuf_writeback;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] num_rows = '0;
    logic [15:0] words_per_row = '0;
    logic [31:0] row_stride = '0;
    logic        hold = 1'b0;
    logic [11:0] obuf_rd_addr;
    logic        obuf_rd_en;
    logic [31:0] omem_addr;
    logic        omem_wr_en, busy, done, err;
`ifdef OBUF_WB_PERF_EN
    logic [31:0] wb_cycles;
`endif

    obuf_writeback dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .words_per_row(words_per_row), .row_stride(row_stride),
        .hold(hold), .obuf_rd_addr(obuf_rd_addr), .obuf_rd_en(obuf_rd_en),
        .omem_addr(omem_addr), .omem_wr_en(omem_wr_en), .busy(busy), .done(done), .err(err)
`ifdef OBUF_WB_PERF_EN
        , .wb_cycles(wb_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_done_g = -1;
    int done_cnt = 0;
    logic [31:0] rdq[$];
    logic [31:0] wrq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] outs_or();
        return 32'(obuf_rd_en) | 32'(obuf_rd_addr) | 32'(omem_wr_en) | omem_addr |
               32'(busy) | 32'(done) | 32'(err);
    endfunction

    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (rst_n) begin
            if (obuf_rd_en) begin
                chk(!hold, "rd_during_hold", 32'(hold), 32'd0);
                if (rdq.size() == 0) chk(1'b0, "rd_unexpected", 32'(obuf_rd_addr), 32'd0);
                else begin
                    e = rdq.pop_front();
                    chk(32'(obuf_rd_addr) == e, "rd_addr", 32'(obuf_rd_addr), e);
                end
            end
            if (omem_wr_en) begin
                if (wrq.size() == 0) chk(1'b0, "wr_unexpected", omem_addr, 32'd0);
                else begin
                    e = wrq.pop_front();
                    chk(omem_addr == e, "wr_addr", omem_addr, e);
                end
            end
            if (done) begin
                chk(cyc == exp_done_g, "done_cycle", 32'(cyc), 32'(exp_done_g));
                chk(!busy, "busy_at_done", 32'(busy), 32'd0);
                done_cnt++;
            end
        end
    end

    task automatic run_tile(input logic [31:0] base, input logic [15:0] rows, input logic [15:0] wpr,
                            input logic [31:0] stride, input int mode, input bit retrig);
        int s, rem, last, d0;
        logic [31:0] tot;
        bit ok_cfg, eerr;
        tot    = 32'(rows) * 32'(wpr);
        eerr   = tot > 32'd4096;
        ok_cfg = rows != 0 && wpr != 0 && !eerr;
        @(posedge clk); #1;
        s = cyc;
        base_addr = base; num_rows = rows; words_per_row = wpr; row_stride = stride;
        hold = 1'b0; start = 1'b1;
        exp_done_g = ok_cfg ? -1 : s + 2;
        d0 = done_cnt;
        if (ok_cfg) begin
            for (int k = 0; k < int'(tot); k++) rdq.push_back(32'(k));
            for (int r = 0; r < int'(rows); r++)
                for (int c = 0; c < int'(wpr); c++) wrq.push_back(base + 32'(r) * stride + 32'(c));
        end
        rem = ok_cfg ? int'(tot) : 0;
        last = s;
        @(posedge clk); #1;
        do begin
            hold = (mode == 1) ? ($urandom_range(0, 2) == 0) : (mode == 2) ? (cyc == s + 3 || cyc == s + 4) : 1'b0;
            start = retrig && cyc == s + 2;
            base_addr = $urandom; num_rows = 16'($urandom); words_per_row = 16'($urandom); row_stride = $urandom;
            @(negedge clk);
            if (cyc == s + 1) begin
                chk(busy, "busy_after_start", 32'(busy), 32'd1);
                chk(err == eerr, "err_after_start", 32'(err), 32'(eerr));
            end
            if (rem > 0 && !hold) begin
                rem--;
                last = cyc;
            end
            @(posedge clk); #1;
        end while (rem > 0);
        hold = 1'b0;
        start = 1'b0;
        if (ok_cfg) exp_done_g = last + 2;
        while (cyc < exp_done_g) begin
            @(posedge clk); #1;
        end
        start = retrig;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && done_cnt == d0; i++) @(negedge clk);
        chk(done_cnt == d0 + 1, "done_pulse_count", 32'(done_cnt - d0), 32'd1);
        @(negedge clk); #1;
        chk(!busy, "idle_after_done", 32'(busy), 32'd0);
        chk(err == eerr, "err_after_done", 32'(err), 32'(eerr));
        chk(rdq.size() == 0, "reads_missing", 32'(rdq.size()), 32'd0);
        chk(wrq.size() == 0, "writes_missing", 32'(wrq.size()), 32'd0);
`ifdef OBUF_WB_PERF_EN
        chk(wb_cycles == 32'(exp_done_g - s - 1), "wb_cycles", wb_cycles, 32'(exp_done_g - s - 1));
`endif
        rdq.delete();
        wrq.delete();
    endtask

    initial begin
        #1;
        chk(outs_or() == 32'd0, "reset_outputs", outs_or(), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk(outs_or() == 32'd0, "idle_outputs", outs_or(), 32'd0);

        run_tile(32'd100, 16'd2, 16'd3, 32'd10, 0, 1'b0);
        run_tile(32'd100, 16'd2, 16'd3, 32'd10, 2, 1'b0);
        run_tile(32'd500, 16'd0, 16'd5, 32'd10, 0, 1'b0);
        run_tile(32'd500, 16'd3, 16'd0, 32'd10, 1, 1'b0);
        run_tile(32'd7, 16'd64, 16'd65, 32'd100, 0, 1'b0);
        run_tile(32'd40, 16'd1, 16'd2, 32'd3, 0, 1'b0);
        run_tile(32'hFFFF_FFFE, 16'd1, 16'd4, 32'd0, 0, 1'b1);
        run_tile(32'd0, 16'd64, 16'd64, 32'd64, 0, 1'b0);

        @(posedge clk); #1;
        base_addr = 32'd1000; num_rows = 16'd4; words_per_row = 16'd8; row_stride = 32'd16;
        start = 1'b1;
        exp_done_g = -1;
        begin
            int s;
            s = cyc;
            for (int k = 0; k < 32; k++) rdq.push_back(32'(k));
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 8; c++) wrq.push_back(32'd1000 + 32'(r * 16 + c));
            @(posedge clk); #1;
            start = 1'b0;
            while (cyc < s + 10) begin
                @(posedge clk); #1;
            end
        end
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk(outs_or() == 32'd0, "async_reset_outputs", outs_or(), 32'd0);
        rdq.delete();
        wrq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk(outs_or() == 32'd0, "post_reset_quiet", outs_or(), 32'd0);
        run_tile(32'd2000, 16'd2, 16'd5, 32'd100, 0, 1'b0);

        for (int i = 0; i < 12; i++)
            run_tile($urandom, 16'($urandom_range(1, 6)), 16'($urandom_range(1, 6)), $urandom, 1, i % 3 == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
